// File: rtl/amci_block_copier.sv
// Word-by-word memory copier on top of an AMCI master: one read, then one write of
// the captured data, repeated COUNT times; any non-OKAY response aborts the copy.
module amci_block_copier #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [AXI_ADDR_WIDTH-1:0] src_addr,
   input  logic [AXI_ADDR_WIDTH-1:0] dst_addr,
   input  logic [COUNT_WIDTH-1:0]    count,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [1:0]                err_resp,
   output logic [COUNT_WIDTH-1:0]    words_done,
   output logic [AXI_ADDR_WIDTH-1:0] AMCI_RADDR,
   output logic [2:0]                AMCI_RSIZE,
   output logic                      AMCI_READ,
   input  logic [AXI_DATA_WIDTH-1:0] AMCI_RDATA,
   input  logic [1:0]                AMCI_RRESP,
   input  logic                      AMCI_RIDLE,
   output logic [AXI_ADDR_WIDTH-1:0] AMCI_WADDR,
   output logic [AXI_DATA_WIDTH-1:0] AMCI_WDATA,
   output logic [2:0]                AMCI_WSIZE,
   output logic                      AMCI_WRITE,
   input  logic [1:0]                AMCI_WRESP,
   input  logic                      AMCI_WIDLE
);

   localparam int BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
   localparam int ALIGN_BITS     = $clog2(BYTES_PER_WORD);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(BYTES_PER_WORD);
   localparam logic [2:0] XFER_SIZE = 3'(ALIGN_BITS);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FINISH} state_t;

   state_t                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] src_q, dst_q;
   logic [COUNT_WIDTH-1:0]    cnt_q, words_done_q, words_next;
   logic [AXI_DATA_WIDTH-1:0] data_q;
   logic                      wait_first_q, error_q;
   logic [1:0]                err_resp_q;
   logic                      accept, rd_ok, rd_fail, wr_ok, wr_fail;
   logic                      rd_pulse, wr_pulse, finish;

   function automatic logic [AXI_ADDR_WIDTH-1:0] align_addr(input logic [AXI_ADDR_WIDTH-1:0] a);
      return a & ~(ADDR_STEP - AXI_ADDR_WIDTH'(1));
   endfunction

   assign words_next = words_done_q + COUNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      rd_pulse = 1'b0;
      wr_pulse = 1'b0;
      rd_ok    = 1'b0;
      rd_fail  = 1'b0;
      wr_ok    = 1'b0;
      wr_fail  = 1'b0;
      finish   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = (count == '0) ? FINISH : RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            rd_pulse = 1'b1;
            state_d  = RD_WAIT;
         end
         // The master's idle flag lags the request by a cycle, so the first wait cycle is skipped.
         RD_WAIT: begin
            if (!wait_first_q && AMCI_RIDLE) begin
               if (AMCI_RRESP != 2'b00) begin
                  rd_fail = 1'b1;
                  state_d = FINISH;
               end else begin
                  rd_ok   = 1'b1;
                  state_d = WR_ISSUE;
               end
            end
         end
         WR_ISSUE: begin
            wr_pulse = 1'b1;
            state_d  = WR_WAIT;
         end
         WR_WAIT: begin
            if (!wait_first_q && AMCI_WIDLE) begin
               if (AMCI_WRESP != 2'b00) begin
                  wr_fail = 1'b1;
                  state_d = FINISH;
               end else begin
                  wr_ok   = 1'b1;
                  state_d = (words_next < cnt_q) ? RD_ISSUE : FINISH;
               end
            end
         end
         FINISH: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state: status outputs survive until the next accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_first_q <= 1'b0;
         error_q      <= 1'b0;
         err_resp_q   <= 2'b00;
         words_done_q <= '0;
      end else begin
         wait_first_q <= rd_pulse | wr_pulse;
         if (accept) begin
            error_q      <= 1'b0;
            err_resp_q   <= 2'b00;
            words_done_q <= '0;
         end else if (rd_fail) begin
            error_q    <= 1'b1;
            err_resp_q <= AMCI_RRESP;
         end else if (wr_fail) begin
            error_q    <= 1'b1;
            err_resp_q <= AMCI_WRESP;
         end else if (wr_ok) begin
            words_done_q <= words_next;
         end
      end
   end

   // Address/data path; addresses wrap naturally at the top of the address space.
   always_ff @(posedge clk) begin
      if (accept) begin
         src_q <= align_addr(src_addr);
         dst_q <= align_addr(dst_addr);
         cnt_q <= count;
      end else if (wr_ok) begin
         src_q <= src_q + ADDR_STEP;
         dst_q <= dst_q + ADDR_STEP;
      end
      if (rd_ok) data_q <= AMCI_RDATA;
   end

   assign busy       = (state_q != IDLE);
   assign done       = finish;
   assign error      = error_q;
   assign err_resp   = err_resp_q;
   assign words_done = words_done_q;
   assign AMCI_READ  = rd_pulse;
   assign AMCI_RADDR = src_q;
   assign AMCI_RSIZE = XFER_SIZE;
   assign AMCI_WRITE = wr_pulse;
   assign AMCI_WADDR = dst_q;
   assign AMCI_WDATA = data_q;
   assign AMCI_WSIZE = XFER_SIZE;

endmodule

// File: tb/tb_amci_block_copier.sv
// Bench for amci_block_copier: an AMCI slave model with random latency, plus a
// reference model that derives the expected read/write sequence from the copy rules.
module tb_amci_block_copier;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] count;
   logic        busy, done, error;
   logic [1:0]  err_resp;
   logic [15:0] words_done;
   logic [31:0] AMCI_RADDR, AMCI_RDATA, AMCI_WADDR, AMCI_WDATA;
   logic [2:0]  AMCI_RSIZE, AMCI_WSIZE;
   logic        AMCI_READ, AMCI_WRITE, AMCI_RIDLE, AMCI_WIDLE;
   logic [1:0]  AMCI_RRESP, AMCI_WRESP;

   amci_block_copier dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .count(count), .busy(busy), .done(done), .error(error), .err_resp(err_resp),
      .words_done(words_done), .AMCI_RADDR(AMCI_RADDR), .AMCI_RSIZE(AMCI_RSIZE),
      .AMCI_READ(AMCI_READ), .AMCI_RDATA(AMCI_RDATA), .AMCI_RRESP(AMCI_RRESP),
      .AMCI_RIDLE(AMCI_RIDLE), .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA),
      .AMCI_WSIZE(AMCI_WSIZE), .AMCI_WRITE(AMCI_WRITE), .AMCI_WRESP(AMCI_WRESP),
      .AMCI_WIDLE(AMCI_WIDLE)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // slave configuration and observation logs
   logic [31:0] seed = 32'h1234_5678;
   int          rd_err_at = -1, wr_err_at = -1;
   logic [1:0]  rd_err_val = 2'b00, wr_err_val = 2'b00;
   int          rd_idx = 0, wr_idx = 0, done_cnt = 0;
   bit          overlap_seen = 1'b0, slave_busy = 1'b0, timed_out;
   logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];

   // reference model results
   logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
   int          exp_words;
   bit          exp_err;
   logic [1:0]  exp_resp;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ seed;
   endfunction

   // AMCI slave: idle flag stays high (with junk) in the cycle after a pulse, then drops for a random time
   int          r_phase = 0, r_delay = 0, w_phase = 0, w_delay = 0;
   logic [31:0] r_addr;
   logic [1:0]  r_resp_fin, w_resp_fin;
   initial begin
      AMCI_RIDLE = 1'b1; AMCI_WIDLE = 1'b1;
      AMCI_RDATA = '0;   AMCI_RRESP = 2'b00; AMCI_WRESP = 2'b00;
      forever begin
         @(posedge clk); #1;
         if (AMCI_READ && AMCI_WRITE) overlap_seen = 1'b1;
         if (done) done_cnt++;
         if (r_phase == 1) begin
            AMCI_RIDLE = 1'b1; AMCI_RDATA = ~mem_word(r_addr); AMCI_RRESP = 2'b10; r_phase = 2;
         end else if (r_phase == 2) begin
            if (r_delay > 0) begin
               AMCI_RIDLE = 1'b0; r_delay--;
            end else begin
               AMCI_RIDLE = 1'b1; AMCI_RDATA = mem_word(r_addr); AMCI_RRESP = r_resp_fin;
               r_phase = 0; slave_busy = 1'b0;
            end
         end
         if (w_phase == 1) begin
            AMCI_WIDLE = 1'b1; AMCI_WRESP = 2'b01; w_phase = 2;
         end else if (w_phase == 2) begin
            if (w_delay > 0) begin
               AMCI_WIDLE = 1'b0; w_delay--;
            end else begin
               AMCI_WIDLE = 1'b1; AMCI_WRESP = w_resp_fin; w_phase = 0; slave_busy = 1'b0;
            end
         end
         if (AMCI_READ) begin
            if (slave_busy) overlap_seen = 1'b1;
            slave_busy = 1'b1;
            rd_log.push_back(AMCI_RADDR);
            r_addr     = AMCI_RADDR;
            r_resp_fin = (rd_idx == rd_err_at) ? rd_err_val : 2'b00;
            rd_idx++;
            r_delay    = int'($urandom_range(0, 3));
            r_phase    = 1;
         end
         if (AMCI_WRITE) begin
            if (slave_busy) overlap_seen = 1'b1;
            slave_busy = 1'b1;
            wr_addr_log.push_back(AMCI_WADDR);
            wr_data_log.push_back(AMCI_WDATA);
            w_resp_fin = (wr_idx == wr_err_at) ? wr_err_val : 2'b00;
            wr_idx++;
            w_delay    = int'($urandom_range(0, 3));
            w_phase    = 1;
         end
      end
   end

   task automatic clear_logs();
      rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
      rd_idx = 0; wr_idx = 0; done_cnt = 0;
   endtask

   // Expected behaviour from the copy rules: read, write same word, step by 4, stop on error.
   task automatic model_copy(input logic [31:0] s0, input logic [31:0] d0, input int n);
      logic [31:0] s, d;
      s = s0 & ~32'h3;
      d = d0 & ~32'h3;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      exp_words = 0; exp_err = 1'b0; exp_resp = 2'b00;
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(s);
         if (i == rd_err_at) begin exp_err = 1'b1; exp_resp = rd_err_val; break; end
         exp_wa.push_back(d);
         exp_wd.push_back(mem_word(s));
         if (i == wr_err_at) begin exp_err = 1'b1; exp_resp = wr_err_val; break; end
         exp_words++;
         s = s + 32'd4;
         d = d + 32'd4;
      end
   endtask

   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      clear_logs();
      model_copy(s, d, n);
      @(posedge clk); #2;
      start = 1'b1; src_addr = s; dst_addr = d; count = 16'(n);
      @(posedge clk); #2;
      start = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (done_cnt > 0 && !busy) begin timed_out = 1'b0; break; end
         @(posedge clk); #2;
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
      checks++; if (err_resp !== 2'b00) begin errors++; $display("FAIL reset_err_resp: got %h want 0", err_resp); end
      checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_done); end
      checks++; if ({AMCI_READ, AMCI_WRITE} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {AMCI_READ, AMCI_WRITE}); end
      reset = 1'b0;
   endtask

   task automatic test_basic_copy();
      rd_err_at = -1; wr_err_at = -1;
      run_copy(32'h1000, 32'h2000, 4);
      checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
      checks++; if (rd_log.size() !== 4 || wr_addr_log.size() !== 4) begin
         errors++; $display("FAIL basic_counts: got %0d reads %0d writes want 4/4", rd_log.size(), wr_addr_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (rd_log[i] !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL basic_raddr[%0d]: got %h want %h", i, rd_log[i], 32'h1000 + 32'(4 * i)); end
            checks++; if (wr_addr_log[i] !== 32'h2000 + 32'(4 * i)) begin errors++; $display("FAIL basic_waddr[%0d]: got %h want %h", i, wr_addr_log[i], 32'h2000 + 32'(4 * i)); end
            checks++; if (wr_data_log[i] !== mem_word(32'h1000 + 32'(4 * i))) begin errors++; $display("FAIL basic_wdata[%0d]: got %h want %h", i, wr_data_log[i], mem_word(32'h1000 + 32'(4 * i))); end
         end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
      checks++; if (words_done !== 16'd4) begin errors++; $display("FAIL basic_words: got %0d want 4", words_done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", error); end
   endtask

   task automatic test_zero_count();
      clear_logs();
      @(posedge clk); #2;
      start = 1'b1; src_addr = 32'h3000; dst_addr = 32'h4000; count = 16'd0;
      @(posedge clk); #2;
      start = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_done_cycle: got done=%b busy=%b want 1/1", done, busy); end
      @(posedge clk); #2;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b want 0/0", done, busy); end
      repeat (3) @(posedge clk);
      #2;
      checks++; if (rd_log.size() + wr_addr_log.size() !== 0) begin errors++; $display("FAIL zero_pulses: got %0d want 0", rd_log.size() + wr_addr_log.size()); end
      checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL zero_words: got %0d want 0", words_done); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_read_error();
      rd_err_at = 1; rd_err_val = 2'd2; wr_err_at = -1;
      run_copy(32'h6000, 32'h7000, 3);
      checks++; if (timed_out) begin errors++; $display("FAIL rderr_timeout: got no done want done"); end
      checks++; if (rd_log.size() !== 2) begin errors++; $display("FAIL rderr_reads: got %0d want 2", rd_log.size()); end
      checks++; if (wr_addr_log.size() !== 1) begin errors++; $display("FAIL rderr_writes: got %0d want 1", wr_addr_log.size()); end
      checks++; if (error !== 1'b1 || err_resp !== 2'd2) begin errors++; $display("FAIL rderr_status: got err=%b resp=%0d want 1/2", error, err_resp); end
      checks++; if (words_done !== 16'd1) begin errors++; $display("FAIL rderr_words: got %0d want 1", words_done); end
      rd_err_at = -1;
   endtask

   task automatic test_write_error();
      wr_err_at = 0; wr_err_val = 2'd3; rd_err_at = -1;
      run_copy(32'h8000, 32'h9000, 2);
      checks++; if (timed_out) begin errors++; $display("FAIL wrerr_timeout: got no done want done"); end
      checks++; if (rd_log.size() !== 1) begin errors++; $display("FAIL wrerr_reads: got %0d want 1", rd_log.size()); end
      checks++; if (error !== 1'b1 || err_resp !== 2'd3) begin errors++; $display("FAIL wrerr_status: got err=%b resp=%0d want 1/3", error, err_resp); end
      checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL wrerr_words: got %0d want 0", words_done); end
      wr_err_at = -1;
   endtask

   task automatic test_wrap_align();
      run_copy(32'hFFFF_FFFC, 32'h0000_0100, 2);
      checks++; if (rd_log.size() !== 2) begin errors++; $display("FAIL wrap_reads: got %0d want 2", rd_log.size()); end
      else begin
         checks++; if (rd_log[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", rd_log[1]); end
      end
      run_copy(32'h1003, 32'h2006, 1);
      checks++; if (rd_log.size() !== 1 || wr_addr_log.size() !== 1) begin errors++; $display("FAIL align_counts: got %0d/%0d want 1/1", rd_log.size(), wr_addr_log.size()); end
      else begin
         checks++; if (rd_log[0] !== 32'h1000) begin errors++; $display("FAIL align_raddr: got %h want 00001000", rd_log[0]); end
         checks++; if (wr_addr_log[0] !== 32'h2004) begin errors++; $display("FAIL align_waddr: got %h want 00002004", wr_addr_log[0]); end
         checks++; if (wr_data_log[0] !== mem_word(32'h1000)) begin errors++; $display("FAIL align_wdata: got %h want %h", wr_data_log[0], mem_word(32'h1000)); end
      end
   endtask

   task automatic test_random_copies();
      for (int t = 0; t < 8; t++) begin
         logic [31:0] s, d;
         int n;
         seed = $urandom;
         s = $urandom; d = $urandom;
         n = int'($urandom_range(1, 6));
         rd_err_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
         wr_err_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
         rd_err_val = 2'($urandom_range(1, 3));
         wr_err_val = 2'($urandom_range(1, 3));
         run_copy(s, d, n);
         checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: got no done want done", t); end
         checks++; if (rd_log.size() !== exp_rd.size() || wr_addr_log.size() !== exp_wa.size()) begin
            errors++; $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", t, rd_log.size(), wr_addr_log.size(), exp_rd.size(), exp_wa.size());
         end else begin
            for (int i = 0; i < exp_rd.size(); i++) begin
               checks++; if (rd_log[i] !== exp_rd[i]) begin errors++; $display("FAIL rand%0d_raddr[%0d]: got %h want %h", t, i, rd_log[i], exp_rd[i]); end
            end
            for (int i = 0; i < exp_wa.size(); i++) begin
               checks++; if (wr_addr_log[i] !== exp_wa[i] || wr_data_log[i] !== exp_wd[i]) begin
                  errors++; $display("FAIL rand%0d_write[%0d]: got %h:%h want %h:%h", t, i, wr_addr_log[i], wr_data_log[i], exp_wa[i], exp_wd[i]);
               end
            end
         end
         checks++; if (words_done !== 16'(exp_words)) begin errors++; $display("FAIL rand%0d_words: got %0d want %0d", t, words_done, exp_words); end
         checks++; if (error !== exp_err) begin errors++; $display("FAIL rand%0d_error: got %b want %b", t, error, exp_err); end
         if (exp_err) begin
            checks++; if (err_resp !== exp_resp) begin errors++; $display("FAIL rand%0d_resp: got %0d want %0d", t, err_resp, exp_resp); end
         end
         checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d want 1", t, done_cnt); end
      end
      rd_err_at = -1; wr_err_at = -1;
   endtask

   task automatic test_start_ignored();
      clear_logs();
      @(posedge clk); #2;
      start = 1'b1; src_addr = 32'h3000; dst_addr = 32'h4000; count = 16'd3;
      @(posedge clk); #2;
      start = 1'b1; src_addr = 32'h9000; dst_addr = 32'h9100; count = 16'd1;
      @(posedge clk); #2;
      start = 1'b0;
      for (int c = 0; c < 200 && done !== 1'b1; c++) begin @(posedge clk); #2; end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_reach_finish: got %b want 1", done); end
      start = 1'b1; src_addr = 32'hA000; count = 16'd0;
      @(posedge clk); #2;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_finish_start: got busy=%b want 0", busy); end
      repeat (5) @(posedge clk);
      #2;
      checks++; if (rd_log.size() !== 3) begin errors++; $display("FAIL ign_reads: got %0d want 3", rd_log.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (rd_log[i] !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL ign_raddr[%0d]: got %h want %h", i, rd_log[i], 32'h3000 + 32'(4 * i)); end
         end
      end
      checks++; if (done_cnt !== 1 || words_done !== 16'd3) begin errors++; $display("FAIL ign_result: got done=%0d words=%0d want 1/3", done_cnt, words_done); end
   endtask

   task automatic test_reset_midway();
      clear_logs();
      @(posedge clk); #2;
      start = 1'b1; src_addr = 32'h5000; dst_addr = 32'h5800; count = 16'd4;
      @(posedge clk); #2;
      start = 1'b0;
      for (int c = 0; c < 50 && rd_log.size() == 0; c++) begin @(posedge clk); #2; end
      checks++; if (rd_log.size() !== 1) begin errors++; $display("FAIL mid_first_read: got %0d want 1", rd_log.size()); end
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got busy=%b done=%b want 0/0", busy, done); end
      checks++; if ({AMCI_READ, AMCI_WRITE} !== 2'b00 || words_done !== 16'd0) begin errors++; $display("FAIL mid_reset_outs: got %b words=%0d want 00/0", {AMCI_READ, AMCI_WRITE}, words_done); end
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      checks++; if (rd_log.size() !== 1 || wr_addr_log.size() !== 0) begin errors++; $display("FAIL mid_no_pulses: got %0d/%0d want 1/0", rd_log.size(), wr_addr_log.size()); end
   endtask

   task automatic test_protocol();
      checks++; if (AMCI_RSIZE !== 3'd2 || AMCI_WSIZE !== 3'd2) begin errors++; $display("FAIL size: got %0d/%0d want 2/2", AMCI_RSIZE, AMCI_WSIZE); end
      checks++; if (overlap_seen !== 1'b0) begin errors++; $display("FAIL outstanding: got overlap=%b want 0", overlap_seen); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0;
      test_reset();
      test_basic_copy();
      test_zero_count();
      test_read_error();
      test_write_error();
      test_wrap_align();
      test_random_copies();
      test_start_ignored();
      test_reset_midway();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
